// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue path: operation codes,
// controller states, default latencies and small opcode classifiers.
package md_pkg;

    // Same encoding is used by the decoder and the multiply/divide unit.
    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MFHI  = 4'd7,
        MFLO  = 4'd8
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } md_state_t;

    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;
    localparam int DEF_CNT_W   = 4;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return (op == MTHI) || (op == MTLO);
    endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Loadable down-counter timing a multiply/divide operation; holds at zero.
module md_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller for the HI/LO multiply/divide unit: starts ops,
// times their latency, pulses the commit and stalls dependent D-stage HI/LO ops.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_valid,
    input  logic [3:0] e_op,
    input  logic       e_flush,
    input  logic       d_uses_hilo,
    output logic       md_start,
    output logic [3:0] md_mode,
    output logic       mt_we,
    output logic       busy,
    output logic       done,
    output logic       stall_d,
    output logic       err
);

    // The issue cycle and the COMMIT cycle are both part of the latency,
    // so RUN only has to cover LAT-2 further counts.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

    md_state_t        state, state_next;
    logic             e_live;
    logic             idle;
    logic             issue;
    logic             violation;
    logic             cnt_zero;
    logic [CNT_W-1:0] load_val;

    always_comb begin
        e_live    = e_valid & ~e_flush;
        idle      = (state == IDLE);
        issue     = e_live & is_muldiv(e_op) & idle;
        mt_we     = e_live & is_mt(e_op) & idle;
        // A flushed instruction never reaches the unit, so it cannot collide.
        violation = e_live & (is_muldiv(e_op) | is_mt(e_op)) & ~idle;
        md_start  = issue;
        md_mode   = (issue | mt_we) ? e_op : NONE;
        load_val  = is_div(e_op) ? DIV_LOAD : MUL_LOAD;
        stall_d   = d_uses_hilo & (issue | busy);
    end

    md_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (issue),
        .load_val (load_val),
        .dec      (state == RUN),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = RUN;
            RUN:     if (cnt_zero) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so they come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == COMMIT);
            err   <= err | violation;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed vector table plus randomized run checked against a cycle-timeline model.
module tb_md_issue_ctrl;
    import md_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic       clk;
    logic       reset;
    logic       e_valid;
    logic [3:0] e_op;
    logic       e_flush;
    logic       d_uses_hilo;
    logic       md_start;
    logic [3:0] md_mode;
    logic       mt_we;
    logic       busy;
    logic       done;
    logic       stall_d;
    logic       err;

    md_issue_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .e_valid     (e_valid),
        .e_op        (e_op),
        .e_flush     (e_flush),
        .d_uses_hilo (d_uses_hilo),
        .md_start    (md_start),
        .md_mode     (md_mode),
        .mt_we       (mt_we),
        .busy        (busy),
        .done        (done),
        .stall_d     (stall_d),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] op;
        logic       fl;
        logic       d;
        logic       start;
        logic [3:0] mode;
        logic       we;
        logic       bsy;
        logic       dn;
        logic       stall;
        logic       er;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic v, input logic [3:0] op,
                                input logic fl, input logic d, input logic start,
                                input logic [3:0] mode, input logic we, input logic bsy,
                                input logic dn, input logic stall, input logic er);
        vec_t r;
        r.rst = rst; r.v = v; r.op = op; r.fl = fl; r.d = d;
        r.start = start; r.mode = mode; r.we = we; r.bsy = bsy;
        r.dn = dn; r.stall = stall; r.er = er;
        return r;
    endfunction

    task automatic drive(input logic rst, input logic v, input logic [3:0] op,
                         input logic fl, input logic d);
        reset = rst; e_valid = v; e_op = op; e_flush = fl; d_uses_hilo = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int         end_cyc;
        logic       m_err;
        logic       r_rst, r_v, r_fl, r_d;
        logic [3:0] r_op;
        logic       idle, live, e_start, e_we, want_done;
        logic [3:0] e_mode;
        int         lat;

        drive(1'b1, 1'b0, NONE, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // rst v op fl d | start mode we busy done stall err ; row index == cycle
        vecs.push_back(mk(1,0,NONE ,0,0, 0,NONE ,0,0,0,0,0)); // 0
        vecs.push_back(mk(0,0,NONE ,0,0, 0,NONE ,0,0,0,0,0)); // 1
        vecs.push_back(mk(0,1,MULT ,0,0, 1,MULT ,0,0,0,0,0)); // 2 issue MULT
        vecs.push_back(mk(0,0,NONE ,0,1, 0,NONE ,0,1,0,1,0)); // 3
        vecs.push_back(mk(0,1,MTLO ,0,1, 0,NONE ,0,1,0,1,0)); // 4 MTLO while busy
        vecs.push_back(mk(0,0,NONE ,0,1, 0,NONE ,0,1,0,1,1)); // 5
        vecs.push_back(mk(0,0,NONE ,0,1, 0,NONE ,0,1,0,1,1)); // 6
        vecs.push_back(mk(0,0,NONE ,0,1, 0,NONE ,0,1,1,1,1)); // 7 done
        vecs.push_back(mk(0,0,NONE ,0,1, 0,NONE ,0,0,0,0,1)); // 8 released
        vecs.push_back(mk(1,0,NONE ,0,0, 0,NONE ,0,0,0,0,1)); // 9 reset clears err
        vecs.push_back(mk(0,1,MTHI ,0,0, 0,MTHI ,1,0,0,0,0)); // 10
        vecs.push_back(mk(0,1,DIV  ,1,0, 0,NONE ,0,0,0,0,0)); // 11 flushed DIV
        vecs.push_back(mk(0,1,DIVU ,0,0, 1,DIVU ,0,0,0,0,0)); // 12 issue DIVU
        vecs.push_back(mk(0,1,MFHI ,0,0, 0,NONE ,0,1,0,0,0)); // 13 MFHI in E is legal
        for (int i = 14; i <= 21; i++)
            vecs.push_back(mk(0,0,NONE ,0,0, 0,NONE ,0,1,0,0,0));
        vecs.push_back(mk(0,0,NONE ,0,0, 0,NONE ,0,1,1,0,0)); // 22 done
        vecs.push_back(mk(0,1,MULTU,0,1, 1,MULTU,0,0,0,1,0)); // 23 back-to-back
        for (int i = 24; i <= 27; i++)
            vecs.push_back(mk(0,0,NONE ,0,1, 0,NONE ,0,1,0,1,0));
        vecs.push_back(mk(0,0,NONE ,0,1, 0,NONE ,0,1,1,1,0)); // 28 done
        vecs.push_back(mk(0,0,NONE ,0,1, 0,NONE ,0,0,0,0,0)); // 29
        vecs.push_back(mk(0,1,MULT ,0,0, 1,MULT ,0,0,0,0,0)); // 30
        vecs.push_back(mk(0,0,NONE ,0,0, 0,NONE ,0,1,0,0,0)); // 31
        vecs.push_back(mk(1,0,NONE ,0,0, 0,NONE ,0,1,0,0,0)); // 32 reset mid-op
        vecs.push_back(mk(0,0,NONE ,0,0, 0,NONE ,0,0,0,0,0)); // 33
        vecs.push_back(mk(0,0,NONE ,0,0, 0,NONE ,0,0,0,0,0)); // 34
        vecs.push_back(mk(0,0,NONE ,0,0, 0,NONE ,0,0,0,0,0)); // 35 no stale done
        vecs.push_back(mk(0,1,MTHI ,1,0, 0,NONE ,0,0,0,0,0)); // 36 flushed MTHI
        vecs.push_back(mk(0,0,NONE ,0,1, 0,NONE ,0,0,0,0,0)); // 37 idle, no stall

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].op, vecs[i].fl, vecs[i].d);
            @(negedge clk);
            check("start", md_start, vecs[i].start);
            check("mode",  md_mode,  vecs[i].mode);
            check("mt_we", mt_we,    vecs[i].we);
            check("busy",  busy,     vecs[i].bsy);
            check("done",  done,     vecs[i].dn);
            check("stall", stall_d,  vecs[i].stall);
            check("err",   err,      vecs[i].er);
            next_cycle();
        end

        // Model: an op issued at cycle T owns the unit through T+LAT, commits at T+LAT.
        cyc     = 0;
        end_cyc = -1;
        m_err   = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_op  = 4'($urandom_range(0, 10));
            r_fl  = ($urandom_range(0, 7) == 0);
            r_d   = 1'($urandom_range(0, 1));
            if (i >= 980) begin
                r_rst = 1'b0;
                r_v   = 1'b0;
            end
            drive(r_rst, r_v, r_op, r_fl, r_d);

            idle    = (cyc > end_cyc);
            live    = r_v && !r_fl;
            e_start = live && (r_op >= 4'd1) && (r_op <= 4'd4) && idle;
            e_we    = live && (r_op == 4'd5 || r_op == 4'd6) && idle;
            e_mode  = (e_start || e_we) ? r_op : 4'd0;
            lat     = (r_op == 4'd3 || r_op == 4'd4) ? DIV_LAT : MUL_LAT;

            @(negedge clk);
            check("r_start", md_start, e_start);
            check("r_mode",  md_mode,  e_mode);
            check("r_mt_we", mt_we,    e_we);
            check("r_busy",  busy,     !idle);
            check("r_stall", stall_d,  r_d && (e_start || !idle));
            check("r_err",   err,      m_err);
            want_done = (exp_q.size() > 0) && (exp_q[0] == 32'(cyc));
            check("r_done",  done,     want_done);
            if (want_done) void'(exp_q.pop_front());

            if (r_rst) begin
                end_cyc = cyc;
                m_err   = 1'b0;
                exp_q.delete();
            end else begin
                if (live && (r_op >= 4'd1) && (r_op <= 4'd6) && !idle) m_err = 1'b1;
                if (e_start) begin
                    end_cyc = cyc + lat;
                    exp_q.push_back(32'(cyc + lat));
                end
            end
            next_cycle();
        end
        check("pending_done", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
